// File: rtl/arm7tdmi_block_seq.sv
// LDM/STM block-transfer sequencer: walks the register list lowest index first, one memory beat per register.
// Optional abort tracking is enabled by defining BLOCK_SEQ_ABORT_EN.
module arm7tdmi_block_seq #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [NUM_REGS-1:0]  cmd_reglist,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic                 cmd_pre,
  input  logic                 cmd_up,
  input  logic                 cmd_s,
  input  logic                 cmd_load,
  input  logic                 cmd_wb,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_write,
  input  logic                 mem_ack,
`ifdef BLOCK_SEQ_ABORT_EN
  input  logic                 mem_abort,
`endif
  output logic [REG_IDX_W-1:0] beat_reg,
  output logic                 beat_user_bank,
  output logic                 beat_last,
  output logic                 busy,
  output logic                 done,
  output logic                 wb_en,
  output logic [ADDR_W-1:0]    wb_value,
  output logic                 spsr_restore,
  output logic                 abort_out,
  output logic [1:0]           state_dbg
);

  // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // a beat transfers on a rising edge where mem_req && mem_ack, and the beat
  // outputs hold steady until then.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NUM_REGS-1:0] LIST_ONE   = 1;
  localparam logic [NUM_REGS-1:0] PC_BIT     = {1'b1, {(NUM_REGS-1){1'b0}}};
  localparam logic [ADDR_W-1:0]   ADDR_FOUR  = 4;
  localparam logic [ADDR_W-1:0]   ALL_REGS_W = ADDR_W'(NUM_REGS);

  state_t state_q, state_d;

  logic [NUM_REGS-1:0] list_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   wb_val_q;
  logic                write_q, user_q, wb_en_q, spsr_q;

  logic                run, accept, wb_block, abort_q;
  logic [REG_IDX_W:0]  cnt;
  logic [ADDR_W-1:0]   span, off, start_addr, wb_calc;
  logic [NUM_REGS-1:0] list_init;
  logic                pc_load;

  function automatic logic [REG_IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [REG_IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + {{REG_IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  assign run    = (state_q == S_RUN);
  assign accept = (state_q == S_IDLE) && cmd_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_RUN;
      S_RUN:   if (mem_ack && beat_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // An empty list moves the base as if every register were transferred.
  always_comb begin
    cnt       = popcount(cmd_reglist);
    span      = (cnt == '0) ? ALL_REGS_W : ADDR_W'(cnt);
    off       = span << 2;
    list_init = (cmd_reglist == '0) ? PC_BIT : cmd_reglist;
    pc_load   = cmd_load && cmd_reglist[NUM_REGS-1];
    wb_calc   = cmd_up ? (cmd_base + off) : (cmd_base - off);
    case ({cmd_pre, cmd_up})
      2'b01:   start_addr = cmd_base;
      2'b11:   start_addr = cmd_base + ADDR_FOUR;
      2'b00:   start_addr = cmd_base - off + ADDR_FOUR;
      default: start_addr = cmd_base - off;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      list_q   <= '0;
      addr_q   <= '0;
      wb_val_q <= '0;
      write_q  <= 1'b0;
      user_q   <= 1'b0;
      wb_en_q  <= 1'b0;
      spsr_q   <= 1'b0;
    end else if (accept) begin
      list_q   <= list_init;
      addr_q   <= start_addr;
      wb_val_q <= wb_calc;
      write_q  <= !cmd_load;
      user_q   <= cmd_s && !pc_load;
      wb_en_q  <= cmd_wb;
      spsr_q   <= cmd_s && pc_load;
    end else if (run && mem_ack) begin
      list_q <= list_q & (list_q - LIST_ONE);
      addr_q <= addr_q + ADDR_FOUR;
    end
  end

`ifdef BLOCK_SEQ_ABORT_EN
  logic load_q;

  // Abort is sticky for the whole sequence and cleared as DONE hands back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
      load_q  <= 1'b0;
    end else if (accept) begin
      abort_q <= 1'b0;
      load_q  <= cmd_load;
    end else if (state_q == S_DONE) begin
      abort_q <= 1'b0;
    end else if (run && mem_ack && mem_abort) begin
      abort_q <= 1'b1;
    end
  end

  assign wb_block = load_q && abort_q;
`else
  assign abort_q  = 1'b0;
  assign wb_block = 1'b0;
`endif

  always_comb begin
    beat_reg = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (run && list_q[i]) beat_reg = REG_IDX_W'(i);
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = !cmd_ready;
  assign mem_req        = run;
  assign mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_write      = run && write_q;
  assign beat_user_bank = run && user_q;
  assign beat_last      = run && ((list_q & (list_q - LIST_ONE)) == '0);
  assign done           = (state_q == S_DONE);
  assign wb_en          = done && wb_en_q && !wb_block;
  assign wb_value       = wb_val_q;
  assign spsr_restore   = done && spsr_q;
  assign abort_out      = done && abort_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/arm7tdmi_block_seq.md
Name: arm7tdmi_block_seq

Overview:
Multi-cycle sequencer for ARM LDM/STM block data transfers. It accepts a decoded block-transfer command and walks the register list lowest index first. For each transferred register it issues one memory beat with address, register index and user-bank select. At completion it emits the base writeback value and the SPSR->CPSR restore strobe. It sits between decode/execute and the memory interface. It generalises the S-bit user-mode handling to a parametrised register count and address width, and adds the full addressing-mode, writeback and empty-list behaviour.

Parameters:
NUM_REGS, 16, width of the register list and number of architectural registers; the PC is register NUM_REGS-1.
ADDR_W, 32, address and base-register width.
REG_IDX_W, $clog2(NUM_REGS), width of the register index outputs.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; synchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
cmd_reglist  in  NUM_REGS  register list (instr[15:0] when NUM_REGS=16).
cmd_base  in  ADDR_W  value of Rn.
cmd_pre  in  1  P bit.
cmd_up  in  1  U bit.
cmd_s  in  1  S bit (instr[22]).
cmd_load  in  1  L bit.
cmd_wb  in  1  W bit.
mem_req  out  1  beat request; held until mem_ack.
mem_addr  out  ADDR_W  word address of the current beat; bits[1:0] are always 0.
mem_write  out  1  1 for STM, 0 for LDM.
mem_ack  in  1  beat accepted (and load data valid).
beat_reg  out  REG_IDX_W  register index of the current beat.
beat_user_bank  out  1  access user-bank registers for this beat.
beat_last  out  1  current beat is the final beat.
busy  out  1  high whenever not IDLE.
done  out  1  one-cycle completion pulse.
wb_en  out  1  write wb_value to Rn; valid with done.
wb_value  out  ADDR_W  final base value.
spsr_restore  out  1  copy SPSR to CPSR; valid with done.
abort_out  out  1  an abort occurred during the sequence (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset: all outputs go to 0 except cmd_ready, which goes to 1. State is IDLE; internal registers are cleared.
- States:
  - IDLE -> RUN on cmd_valid && cmd_ready. The command is latched in that cycle.
  - RUN -> RUN on mem_ack when the beat is not the last.
  - RUN -> DONE on mem_ack with beat_last.
  - DONE -> IDLE unconditionally after one cycle.
- Beat count: n = popcount(cmd_reglist).
- Empty list (n=0): one beat transferring register NUM_REGS-1. Address and writeback are computed as if n=NUM_REGS, e.g. an increment of 0x40 for 16 registers.
- Start address, using 4*n with ADDR_W-bit modulo arithmetic:
  - IA (P=0,U=1): base.
  - IB (P=1,U=1): base+4.
  - DA (P=0,U=0): base-4n+4.
  - DB (P=1,U=0): base-4n.
- Each subsequent beat uses the previous address +4. Addresses wrap modulo 2^ADDR_W.
- wb_value = U ? base+4n : base-4n. wb_en = cmd_wb.
- mem_req is asserted from the first RUN cycle onward. The first beat is issued the cycle after acceptance.
- mem_addr, beat_reg and beat_last are stable while mem_req && !mem_ack. The next beat is presented the cycle after mem_ack, so there is zero idle cycle between beats when mem_ack is held high.
- beat_user_bank = cmd_s && !(cmd_load && reglist[NUM_REGS-1]). The value is constant across all beats.
- spsr_restore = cmd_s && cmd_load && reglist[NUM_REGS-1], pulsed with done.
- done, wb_en and spsr_restore are high only in the DONE cycle. cmd_valid is ignored outside IDLE.
- Reset asserted mid-sequence:
  - aborts immediately with no done pulse and no writeback;
  - mem_req drops on the next edge.

Optional Feature:
Macro BLOCK_SEQ_ABORT_EN.
- Defined:
  - adds input mem_abort (1 bit), sampled with mem_ack;
  - an abort sets a sticky flag, and the sequence continues to completion (ARM7 behaviour);
  - for loads with the flag set, wb_en is suppressed in DONE, and beat_user_bank is unaffected;
  - abort_out = sticky flag in DONE;
  - the flag clears on entering IDLE.
- Undefined: no mem_abort port; abort_out is tied to 0.

Test Plan:
- LDMIA r0,{r1,r2,r3} (reglist 0x000E, base 0x1000, S=0, W=0) -> beats at 0x1000/0x1004/0x1008, regs 1/2/3, mem_write=0, user_bank=0, done with wb_en=0.
- STMDB r13!,{r4,r5,lr} (0x4030, base 0x2000, W=1) -> beats at 0x1FF4/0x1FF8/0x1FFC, regs 4/5/14, mem_write=1, wb_value=0x1FF4, wb_en=1.
- Same STMDB with S=1 -> user_bank=1 on all 3 beats, spsr_restore=0; LDMIA {r1,r2,r3}^ -> user_bank=1.
- LDMIA {r0,pc}^ (0x8001, S=1) -> user_bank=0 on both beats, spsr_restore=1 with done.
- Empty list, IA, base 0x3000, W=1 -> single beat, reg 15, addr 0x3000, wb_value=0x3040.
- mem_ack held low 3 cycles on beat 2, then rst_n low mid-RUN -> address and reg stable while stalled; after reset mem_req=0, cmd_ready=1, no done pulse.
